// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// ahb_bus_arbiter : round-robin AHB arbiter, burst/lock hold, no-gap hand-over
// Optional split masking: define AHB_ARB_SPLIT_EN          Revision: 1.0
// ============================================================================
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW            = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK_i,
  input  logic                   HRESET_i,
  input  logic [NUM_MASTERS-1:0] HBUSREQ_i,
  input  logic [NUM_MASTERS-1:0] HLOCK_i,
  input  logic [1:0]             HTRANS_i,
  input  logic [2:0]             HBURST_i,
  input  logic                   HREADY_i,
  input  logic [1:0]             HRESP_i,
`ifdef AHB_ARB_SPLIT_EN
  input  logic [NUM_MASTERS-1:0] HSPLIT_i,
`endif
  output logic [NUM_MASTERS-1:0] HGRANT_o,
  output logic [MW-1:0]          HMASTER_o,
  output logic                   HMASTLOCK_o
);

  localparam logic [1:0]             C_TRANS_NONSEQ = 2'd2;
  localparam logic [1:0]             C_TRANS_SEQ    = 2'd3;
  localparam logic [1:0]             C_RESP_OKAY    = 2'd0;
  localparam logic [NUM_MASTERS-1:0] C_ONE          = NUM_MASTERS'(1);
  localparam logic [NUM_MASTERS-1:0] C_GRANT_RST    = C_ONE << DEFAULT_MASTER;
  localparam logic [MW-1:0]          C_MASTER_RST   = MW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] masked;
  logic [NUM_MASTERS-1:0] eligible;
  logic [MW-1:0]          owner;
  logic [MW-1:0]          rr_idx;
  logic [MW-1:0]          win;
  logic                   found;
  logic [3:0]             burst_cnt;
  logic                   hold;

`ifdef AHB_ARB_SPLIT_EN
  localparam logic [1:0] C_RESP_SPLIT = 2'd3;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;

  // A new split on the same edge as its release must win, so the set is applied last.
  always_comb begin
    mask_d = mask_q & ~HSPLIT_i;
    if (!HREADY_i && (HRESP_i == C_RESP_SPLIT)) begin
      mask_d[master_q] = 1'b1;
    end
  end

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign masked = mask_q;
`else
  assign masked = '0;
`endif

  assign eligible = HBUSREQ_i & ~masked;

  always_comb begin
    owner = C_MASTER_RST;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        owner = MW'(i);
      end
    end
  end

  // Search starts one past the last winner, so the last winner is tried last.
  always_comb begin
    found  = 1'b0;
    win    = C_MASTER_RST;
    rr_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      rr_idx = MW'((int'(ptr_q) + k) % NUM_MASTERS);
      if (!found && eligible[rr_idx]) begin
        found = 1'b1;
        win   = rr_idx;
      end
    end
  end

  always_comb begin
    case (HBURST_i)
      3'd0, 3'd1: burst_cnt = 4'd0;
      3'd2, 3'd3: burst_cnt = 4'd3;
      3'd4, 3'd5: burst_cnt = 4'd7;
      default:    burst_cnt = 4'd15;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    ptr_d      = ptr_q;
    hold       = 1'b0;
    if (HREADY_i) begin
      if (HTRANS_i == C_TRANS_NONSEQ) begin
        cnt_d = burst_cnt;
      end else if ((HTRANS_i == C_TRANS_SEQ) && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
      end
      master_d   = owner;
      mastlock_d = HLOCK_i[owner];
      // Releasing at cnt==1 lets the next owner's NONSEQ overlap the final beat.
      hold = (cnt_d >= 4'd2) || (HLOCK_i[owner] && HBUSREQ_i[owner] && !masked[owner]);
      if (!hold) begin
        if (found) begin
          grant_d = C_ONE << win;
          ptr_d   = win;
        end else begin
          grant_d = C_GRANT_RST;
        end
      end
    end else if (HRESP_i != C_RESP_OKAY) begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      grant_q    <= C_GRANT_RST;
      master_q   <= C_MASTER_RST;
      mastlock_q <= 1'b0;
      cnt_q      <= 4'd0;
      ptr_q      <= C_MASTER_RST;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign HGRANT_o    = grant_q;
  assign HMASTER_o   = master_q;
  assign HMASTLOCK_o = mastlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ahb_bus_arbiter : directed scenarios plus randomized run vs. a reference model
// Revision: 1.0
// ============================================================================
module tb_ahb_bus_arbiter;
  localparam int N   = 4;
  localparam int DEF = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans, hresp;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hsplit;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks   = 0;
  int failures = 0;

  // Reference model state, kept as plain integers
  int         m_gnt, m_mst, m_cnt, m_ptr;
  bit         m_lk;
  logic [15:0] m_mask;
  int         beats [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK_i      (clk),
    .HRESET_i    (rst),
    .HBUSREQ_i   (hbusreq),
    .HLOCK_i     (hlock),
    .HTRANS_i    (htrans),
    .HBURST_i    (hburst),
    .HREADY_i    (hready),
    .HRESP_i     (hresp),
`ifdef AHB_ARB_SPLIT_EN
    .HSPLIT_i    (hsplit),
`endif
    .HGRANT_o    (hgrant),
    .HMASTER_o   (hmaster),
    .HMASTLOCK_o (hmastlock)
  );

  function automatic void model_reset();
    m_gnt = DEF; m_mst = DEF; m_lk = 1'b0; m_cnt = 0; m_ptr = DEF; m_mask = '0;
  endfunction

  function automatic void model_step();
    int          cnt_n;
    int          g;
    bit          keep;
    logic [15:0] mask_n;
    g      = m_gnt;
    cnt_n  = m_cnt;
    mask_n = m_mask;
    if (hready) begin
      if (htrans == 2'd2) cnt_n = beats[hburst] - 1;
      else if (htrans == 2'd3 && m_cnt > 0) cnt_n = m_cnt - 1;
    end else if (hresp != 2'd0) begin
      cnt_n = 0;
    end
`ifdef AHB_ARB_SPLIT_EN
    mask_n = m_mask & ~{12'd0, hsplit};
    if (!hready && hresp == 2'd3) mask_n[m_mst] = 1'b1;
`endif
    if (hready) begin
      keep  = (cnt_n >= 2) || (hlock[g] && hbusreq[g] && !m_mask[g]);
      m_mst = g;
      m_lk  = hlock[g];
      if (!keep) begin
        m_gnt = DEF;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (hbusreq[j] && !m_mask[j]) begin
            m_gnt = j;
            m_ptr = j;
            break;
          end
        end
      end
    end
    m_cnt  = cnt_n;
    m_mask = mask_n;
  endfunction

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic rdy, input logic [1:0] resp);
    hbusreq = req; hlock = lock; htrans = trans; hburst = burst; hready = rdy; hresp = resp;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hsplit = '0;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    #1;
    checks++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got g=%b m=%0d l=%b want g=0001 m=0 l=0", hgrant, hmaster, hmastlock);
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({hgrant, hmaster, hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
        failures++;
        $display("FAIL idle_default[%0d]: got g=%b m=%0d l=%b want g=0001 m=0 l=0", i, hgrant, hmaster, hmastlock);
      end
    end
  endtask

  task automatic test_round_robin();
    int eg [4] = '{2, 8, 2, 8};
    int em [4] = '{0, 1, 3, 1};
    do_reset();
    drive(4'b1010, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (hgrant !== 4'(eg[i]) || hmaster !== 2'(em[i])) begin
        failures++;
        $display("FAIL round_robin[%0d]: got g=%b m=%0d want g=%b m=%0d", i, hgrant, hmaster, 4'(eg[i]), em[i]);
      end
    end
  endtask

  task automatic test_burst_handover();
    logic [3:0] eg [4] = '{4'b0100, 4'b0100, 4'b0001, 4'b0001};
    int         em [4] = '{2, 2, 2, 0};
    do_reset();
    drive(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick(); tick();
    checks++;
    if (hgrant !== 4'b0100 || hmaster !== 2'd2) begin
      failures++;
      $display("FAIL burst_setup: got g=%b m=%0d want g=0100 m=2", hgrant, hmaster);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(4'b0101, 4'b0000, 2'd2, 3'd3, 1'b1, 2'd0);
      else if (i == 3) drive(4'b0001, 4'b0000, 2'd3, 3'd3, 1'b1, 2'd0);
      else drive(4'b0101, 4'b0000, 2'd3, 3'd3, 1'b1, 2'd0);
      tick();
      checks++;
      if (hgrant !== eg[i] || hmaster !== 2'(em[i])) begin
        failures++;
        $display("FAIL incr4_beat%0d: got g=%b m=%0d want g=%b m=%0d", i + 1, hgrant, hmaster, eg[i], em[i]);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(4'b0010, 4'b0010, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
    checks++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0010, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL lock_grant: got g=%b m=%0d l=%b want g=0010 m=0 l=0", hgrant, hmaster, hmastlock);
    end
    tick();
    drive(4'b0111, 4'b0010, 2'd2, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({hgrant, hmaster, hmastlock} !== {4'b0010, 2'd1, 1'b1}) begin
        failures++;
        $display("FAIL lock_hold[%0d]: got g=%b m=%0d l=%b want g=0010 m=1 l=1", i, hgrant, hmaster, hmastlock);
      end
    end
    drive(4'b0101, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick();
    checks++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0100, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL lock_release: got g=%b m=%0d l=%b want g=0100 m=1 l=0", hgrant, hmaster, hmastlock);
    end
  endtask

  task automatic test_wait_and_reset();
    logic [3:0] want;
    do_reset();
    drive(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick(); tick();
    drive(4'b0101, 4'b0000, 2'd2, 3'd5, 1'b1, 2'd0);
    tick();
    drive(4'b0101, 4'b0000, 2'd3, 3'd5, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hgrant !== 4'b0100 || hmaster !== 2'd2) begin
        failures++;
        $display("FAIL incr8_wait[%0d]: got g=%b m=%0d want g=0100 m=2", i, hgrant, hmaster);
      end
    end
    hready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      want = (i == 5) ? 4'b0001 : 4'b0100;
      checks++;
      if (hgrant !== want) begin
        failures++;
        $display("FAIL incr8_handover[beat%0d]: got g=%b want g=%b", i + 2, hgrant, want);
      end
    end
    // Second burst, reset asserted mid-cycle during beat 5
    do_reset();
    drive(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick(); tick();
    drive(4'b0101, 4'b0000, 2'd2, 3'd5, 1'b1, 2'd0);
    tick();
    drive(4'b0101, 4'b0000, 2'd3, 3'd5, 1'b1, 2'd0);
    repeat (3) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_burst: got g=%b m=%0d l=%b want g=0001 m=0 l=0", hgrant, hmaster, hmastlock);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0101, 4'b0000, 2'd0, 3'd0, 1'b0, 2'd0);
    tick();
    checks++;
    if (hgrant !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_wait: got g=%b want g=0001", hgrant);
    end
    hready = 1'b1;
    tick();
    checks++;
    if (hgrant !== 4'b0100 || hmaster !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_arb: got g=%b m=%0d want g=0100 m=0", hgrant, hmaster);
    end
  endtask

`ifdef AHB_ARB_SPLIT_EN
  task automatic test_split();
    do_reset();
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    tick(); tick();
    drive(4'b0010, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    tick();
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b0, 2'd3);
    tick();
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd3);
    tick();
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hgrant !== 4'b0001) begin
        failures++;
        $display("FAIL split_masked[%0d]: got g=%b want g=0001", i, hgrant);
      end
      tick();
    end
    hsplit = 4'b0010;
    tick();
    hsplit = 4'b0000;
    checks++;
    if (hgrant !== 4'b0001) begin
      failures++;
      $display("FAIL split_release_edge: got g=%b want g=0001", hgrant);
    end
    tick();
    checks++;
    if (hgrant !== 4'b0010) begin
      failures++;
      $display("FAIL split_regrant: got g=%b want g=0010", hgrant);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      hbusreq = 4'($urandom);
      hlock   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      htrans  = 2'($urandom);
      hburst  = 3'($urandom);
      hready  = ($urandom_range(0, 4) != 0);
      hresp   = (!hready && $urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      hsplit  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      tick();
      checks++;
      if ({hgrant, hmaster, hmastlock} !== {4'(1 << m_gnt), 2'(m_mst), m_lk}) begin
        failures++;
        $display("FAIL random[%0d]: got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                 c, hgrant, hmaster, hmastlock, 4'(1 << m_gnt), m_mst, m_lk);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    hsplit = '0;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    model_reset();
    test_reset();
    test_round_robin();
    test_burst_handover();
    test_lock();
    test_wait_and_reset();
`ifdef AHB_ARB_SPLIT_EN
    test_split();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB bus arbiter for up to NUM_MASTERS bus masters sharing one address/data bus, such as multiple ahb_frbm instances driving the ahb_gen_slave decode.
- Samples HBUSREQ/HLOCK and the shared bus control (HTRANS, HBURST, HREADY, HRESP).
- Drives HGRANT to the masters, and HMASTER/HMASTLOCK to the address/data muxes and slaves.
- Holds the grant through locked sequences and fixed-length bursts.
- Hands the bus over so the next master's address phase follows the current master's last beat directly, with no dead cycle.

## Interface
- NUM_MASTERS, 4, number of masters, 2..16
- DEFAULT_MASTER, 0, index granted when no master requests; also the reset owner
- MW, $clog2(NUM_MASTERS), HMASTER width (derived, not overridden)
- HCLK  in  1  bus clock; all state updates on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request
- HTRANS  in  2  muxed transfer type of the current owner (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
- HBURST  in  3  muxed burst type of the current owner
- HREADY  in  1  shared transfer-complete
- HRESP  in  2  shared response (0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT)
- HSPLIT  in  NUM_MASTERS  slave split-release strobes (present only with AHB_ARB_SPLIT_EN)
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  MW  owner of the current address phase, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Reset values:
  - HGRANT = one-hot(DEFAULT_MASTER)
  - HMASTER = DEFAULT_MASTER
  - HMASTLOCK = 0
  - beat counter = 0
  - round-robin pointer = DEFAULT_MASTER
  - split mask = 0
- Beat counter (cnt, 4 bits) counts beats still to be issued after the currently accepted address. It updates only on edges with HREADY=1:
  - NONSEQ: cnt loads beats-1 (SINGLE/INCR give 0; WRAP4/INCR4 give 3; 8-beat bursts give 7; 16-beat bursts give 15).
  - SEQ with cnt>0: cnt decrements.
  - IDLE/BUSY: cnt unchanged.
- Error responses: the first cycle of ERROR, RETRY or SPLIT (HREADY=0) forces cnt=0, abandoning the burst.
- Hold condition, evaluated at each HREADY=1 edge: HGRANT is held unchanged if either of the following is true after the cnt update:
  - cnt≥2;
  - the granted master has HLOCK=1 and HBUSREQ=1.
- Otherwise HGRANT is re-arbitrated:
  - Search eligible requesters round-robin, starting at pointer+1 and wrapping modulo NUM_MASTERS.
  - The first requester found is granted and the pointer is set to it.
  - If there are no eligible requesters, DEFAULT_MASTER is granted and the pointer is unchanged.
- The current owner is re-granted if it is the only requester.
- When HREADY=0, HGRANT, HMASTER, HMASTLOCK and the pointer are held.
- Address-phase ownership: on each HREADY=1 edge, HMASTER and HMASTLOCK are loaded from the pre-edge HGRANT index and HLOCK bit.
- INCR (undefined length) bursts are not protected. The master must use HLOCK if it needs the bus held across beats.

## Timing
- Request to grant: 1 HREADY-qualified edge when the bus is free.
- Grant to HMASTER: 1 further HREADY-qualified edge.
- Fixed burst of N beats: HGRANT may move at the edge accepting beat N-1. The new owner's NONSEQ follows beat N with no dead cycle.
- HREADY low for k cycles delays every update by exactly k cycles.
- Reset asserted mid-burst immediately returns all outputs to reset values. The first arbitration after release occurs at the first HREADY=1 edge.
- Simultaneous requests are resolved by the pointer only. There are no fixed priorities.

## Configuration
- AHB_ARB_SPLIT_EN defined:
  - HSPLIT port exists.
  - The first SPLIT response cycle sets split-mask bit HMASTER.
  - HSPLIT[i]=1 clears bit i; if a set and a clear hit the same bit on the same edge, the set wins.
  - Masked masters are ineligible and their HLOCK is ignored.
  - If every requester is masked, DEFAULT_MASTER is granted.
- AHB_ARB_SPLIT_EN undefined: HSPLIT is absent, there is no split mask, and SPLIT is handled exactly as RETRY.

## Test plan
- Reset, then NUM_MASTERS=4 with no requests -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 held indefinitely.
- HBUSREQ=1010 held, owner issuing SINGLE transfers with HREADY=1 -> grant order M1,M3,M1,M3; HMASTER trails HGRANT by one cycle.
- M2 issues INCR4 while M0 requests -> HGRANT stays 0100 through the NONSEQ and first SEQ edges and moves to 0001 at the edge accepting beat 3; M0 NONSEQ directly follows beat 4.
- M1 with HLOCK=1 performs 3 SINGLEs while M0, M2 request -> HGRANT=0010 throughout, HMASTLOCK=1 on those address phases; after HLOCK drops, the next grant goes to M2.
- INCR8 with HREADY=0 for 3 cycles on beat 2 -> hand-over edge delayed by exactly 3 cycles; HRESET pulse on beat 5 -> outputs at reset values immediately.
- AHB_ARB_SPLIT_EN: M1 gets SPLIT, HBUSREQ=0010 -> HGRANT=0001 until HSPLIT=0010 pulse, then HGRANT=0010 on the following HREADY edge.
